// File: rtl/ram_rmw_ctrl.sv
// CPU load/store front-end for a 32-bit word RAM: accepts byte/half/word requests,
// performs read-modify-write for sub-word stores and returns one response per request.
module ram_rmw_ctrl #(
  parameter int unsigned DEPTH = 4096
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_i,
  output logic        ready_o,
  input  logic        we_i,
  input  logic [1:0]  size_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] wdata_i,
  output logic        rsp_valid_o,
  output logic [31:0] rdata_o,
  output logic        err_o,
  output logic        ram_we_o,
  output logic [31:0] ram_addr_o,
  output logic [31:0] ram_data_o,
  input  logic [31:0] ram_data_i
);

  localparam int unsigned DW     = 32;
  localparam int unsigned WIDX_W = 30;
  localparam logic [WIDX_W-1:0] LP_DEPTH = WIDX_W'(DEPTH);

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_READ  = 2'd1,
    S_WRITE = 2'd2,
    S_RESP  = 2'd3
  } state_t;

  state_t r_state;
  state_t w_next;

  logic          r_we;
  logic [1:0]    r_size;
  logic [31:0]   r_addr;
  logic [DW-1:0] r_wdata;
  logic          r_err;

  logic          r_ready;
  logic          r_rsp_valid;
  logic [DW-1:0] r_rdata;
  logic          r_err_o;
  logic          r_ram_we;
  logic [31:0]   r_ram_addr;
  logic [DW-1:0] r_ram_data;

  logic          w_accept;
  logic          w_req_err;
  logic          w_err_sel;
  logic [DW-1:0] w_merged;
  logic [DW-1:0] w_lane;
  logic [31:0]   w_word_addr;
  logic [DW-1:0] w_ram_data_nxt;
  logic [31:0]   w_ram_addr_nxt;
  logic [DW-1:0] w_rdata_nxt;

  assign w_accept = req_i & r_ready;

  // Request legality, evaluated on the raw inputs in the accept cycle
  always_comb begin
    w_req_err = 1'b0;
    if (size_i == 2'b11)                              w_req_err = 1'b1;
    if ((size_i == SZ_HALF) && addr_i[0])             w_req_err = 1'b1;
    if ((size_i == SZ_WORD) && (addr_i[1:0] != 2'b00)) w_req_err = 1'b1;
    if (addr_i[31:2] >= LP_DEPTH)                     w_req_err = 1'b1;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          if (w_req_err)                 w_next = S_RESP;
          else if (!we_i)                w_next = S_READ;
          else if (size_i == SZ_WORD)    w_next = S_WRITE;
          else                           w_next = S_READ;
        end
      end
      S_READ:  w_next = r_we ? S_WRITE : S_RESP;
      S_WRITE: w_next = S_RESP;
      S_RESP:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  // Held request, captured only on a handshake
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_we    <= 1'b0;
      r_size  <= 2'b00;
      r_addr  <= 32'd0;
      r_wdata <= '0;
      r_err   <= 1'b0;
    end else if (w_accept) begin
      r_we    <= we_i;
      r_size  <= size_i;
      r_addr  <= addr_i;
      r_wdata <= wdata_i;
      r_err   <= w_req_err;
    end
  end

  // Sub-word store: replace only the addressed lane of the word just read
  always_comb begin
    w_merged = ram_data_i;
    case (r_size)
      SZ_BYTE: begin
        case (r_addr[1:0])
          2'd0:    w_merged[7:0]   = r_wdata[7:0];
          2'd1:    w_merged[15:8]  = r_wdata[7:0];
          2'd2:    w_merged[23:16] = r_wdata[7:0];
          default: w_merged[31:24] = r_wdata[7:0];
        endcase
      end
      SZ_HALF: begin
        if (r_addr[1]) w_merged[31:16] = r_wdata[15:0];
        else           w_merged[15:0]  = r_wdata[15:0];
      end
      default: w_merged = r_wdata;
    endcase
  end

  // Load: right-align the addressed lane, zero-extended
  always_comb begin
    w_lane = '0;
    case (r_size)
      SZ_BYTE: begin
        case (r_addr[1:0])
          2'd0:    w_lane = {24'd0, ram_data_i[7:0]};
          2'd1:    w_lane = {24'd0, ram_data_i[15:8]};
          2'd2:    w_lane = {24'd0, ram_data_i[23:16]};
          default: w_lane = {24'd0, ram_data_i[31:24]};
        endcase
      end
      SZ_HALF: begin
        if (r_addr[1]) w_lane = {16'd0, ram_data_i[31:16]};
        else           w_lane = {16'd0, ram_data_i[15:0]};
      end
      default: w_lane = ram_data_i;
    endcase
  end

  // Outputs are registered from the next state; accept-cycle values come from the inputs
  always_comb begin
    w_err_sel      = (r_state == S_IDLE) ? w_req_err : r_err;
    w_word_addr    = (r_state == S_IDLE) ? {addr_i[31:2], 2'b00} : {r_addr[31:2], 2'b00};
    w_ram_addr_nxt = 32'd0;
    w_ram_data_nxt = '0;
    w_rdata_nxt    = '0;
    if ((w_next == S_READ) || (w_next == S_WRITE)) w_ram_addr_nxt = w_word_addr;
    if (w_next == S_WRITE) w_ram_data_nxt = (r_state == S_IDLE) ? wdata_i : w_merged;
    if ((w_next == S_RESP) && (r_state == S_READ)) w_rdata_nxt = w_lane;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ready     <= 1'b1;
      r_rsp_valid <= 1'b0;
      r_rdata     <= '0;
      r_err_o     <= 1'b0;
      r_ram_we    <= 1'b0;
      r_ram_addr  <= 32'd0;
      r_ram_data  <= '0;
    end else begin
      r_ready     <= (w_next == S_IDLE);
      r_rsp_valid <= (w_next == S_RESP);
      r_rdata     <= w_rdata_nxt;
      r_err_o     <= (w_next == S_RESP) & w_err_sel;
      r_ram_we    <= (w_next == S_WRITE);
      r_ram_addr  <= w_ram_addr_nxt;
      r_ram_data  <= w_ram_data_nxt;
    end
  end

  assign ready_o     = r_ready;
  assign rsp_valid_o = r_rsp_valid;
  assign rdata_o     = r_rdata;
  assign err_o       = r_err_o;
  assign ram_we_o    = r_ram_we;
  assign ram_addr_o  = r_ram_addr;
  assign ram_data_o  = r_ram_data;

endmodule

// File: tb/tb_ram_rmw_ctrl.sv
// Bench for ram_rmw_ctrl: directed vector table, hand sequences for back-to-back and
// mid-write reset, then random requests against a byte-lane memory model.
module tb_ram_rmw_ctrl;

  localparam int unsigned DEPTH = 4096;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_i = 1'b0;
  logic        ready_o;
  logic        we_i = 1'b0;
  logic [1:0]  size_i = 2'b00;
  logic [31:0] addr_i = 32'd0;
  logic [31:0] wdata_i = 32'd0;
  logic        rsp_valid_o;
  logic [31:0] rdata_o;
  logic        err_o;
  logic        ram_we_o;
  logic [31:0] ram_addr_o;
  logic [31:0] ram_data_o;
  logic [31:0] ram_data_i;

  ram_rmw_ctrl #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .req_i(req_i), .ready_o(ready_o), .we_i(we_i),
    .size_i(size_i), .addr_i(addr_i), .wdata_i(wdata_i), .rsp_valid_o(rsp_valid_o),
    .rdata_o(rdata_o), .err_o(err_o), .ram_we_o(ram_we_o), .ram_addr_o(ram_addr_o),
    .ram_data_o(ram_data_o), .ram_data_i(ram_data_i)
  );

  always #5 clk = ~clk;

  // Physical RAM seen by the DUT
  logic [31:0] ram [DEPTH];
  logic        ram_init = 1'b1;
  assign ram_data_i = ram[ram_addr_o[13:2]];
  always @(posedge clk) begin
    if (ram_init) begin
      for (int i = 0; i < int'(DEPTH); i++) ram[i] <= 32'd0;
    end else if (ram_we_o) begin
      ram[ram_addr_o[13:2]] <= ram_data_o;
    end
  end

  // Reference memory contents as the CPU should see them
  logic [31:0] mdl [DEPTH];
  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s[%0d] act=%h exp=%h", name, idx, act, exp);
    end
  endtask

  task automatic model(input logic we, input logic [1:0] size, input logic [31:0] addr,
                       input logic [31:0] wdata, output logic err, output logic [31:0] rdata,
                       output int lat, output int nwe, output logic [31:0] wword);
    logic [63:0] mask, w64, nw64;
    int nbytes, sh;
    logic [29:0] widx;
    widx = addr[31:2];
    err = (size == 2'd3) || (size == 2'd1 && addr[0]) || (size == 2'd2 && addr[1:0] != 2'd0)
          || (widx >= 30'(DEPTH));
    rdata = 32'd0; wword = 32'd0; nwe = 0;
    if (err) begin
      lat = 1;
    end else begin
      nbytes = 1 << size;
      sh     = 8 * int'(addr[1:0]);
      mask   = (64'd1 << (8 * nbytes)) - 64'd1;
      w64    = {32'd0, mdl[addr[13:2]]};
      if (!we) begin
        nw64  = (w64 >> sh) & mask;
        rdata = nw64[31:0];
        lat   = 2;
      end else begin
        nw64  = (w64 & ~(mask << sh)) | (({32'd0, wdata} & mask) << sh);
        wword = nw64[31:0];
        mdl[addr[13:2]] = wword;
        nwe   = 1;
        lat   = (size == 2'd2) ? 2 : 3;
      end
    end
  endtask

  task automatic do_req(input logic we, input logic [1:0] size, input logic [31:0] addr,
                        input logic [31:0] wdata, output logic err, output logic [31:0] rdata,
                        output int lat, output int nwe, output logic [31:0] waddr,
                        output logic [31:0] wdat, output logic busy_ok);
    int guard;
    bit got;
    err = 1'b0; rdata = 32'd0; lat = 0; nwe = 0; waddr = 32'd0; wdat = 32'd0;
    busy_ok = 1'b1; got = 1'b0; guard = 0;
    @(negedge clk);
    req_i = 1'b1; we_i = we; size_i = size; addr_i = addr; wdata_i = wdata;
    while (!ready_o && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    @(posedge clk);
    #1;
    // inputs only need to be valid in the accept cycle
    req_i = 1'b0; we_i = 1'($urandom); size_i = 2'($urandom);
    addr_i = $urandom; wdata_i = $urandom;
    for (int k = 1; k <= 12 && !got; k++) begin
      if (k > 1) begin
        @(posedge clk);
        #1;
      end
      if (ready_o) busy_ok = 1'b0;
      if (ram_we_o) begin
        nwe++;
        waddr = ram_addr_o;
        wdat  = ram_data_o;
      end
      if (rsp_valid_o) begin
        got = 1'b1; lat = k; err = err_o; rdata = rdata_o;
      end
    end
    if (got) begin
      @(posedge clk);
      #1;
      if (!ready_o || rsp_valid_o || ram_we_o || ram_addr_o != 32'd0 || ram_data_o != 32'd0)
        busy_ok = 1'b0;
    end
  endtask

  typedef struct {
    logic        we;
    logic [1:0]  size;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        err;
    logic [31:0] rdata;
    int          lat;
    logic [31:0] wword;
  } vec_t;

  localparam int NV = 20;
  vec_t vt [NV];

  task automatic check_req(input string tag, input int idx, input logic we, input logic [1:0] size,
                           input logic [31:0] addr, input logic [31:0] wdata, input logic e_err,
                           input logic [31:0] e_rdata, input int e_lat, input logic [31:0] e_wword);
    logic err, busy_ok;
    logic [31:0] rdata, waddr, wdat;
    int lat, nwe, e_nwe;
    do_req(we, size, addr, wdata, err, rdata, lat, nwe, waddr, wdat, busy_ok);
    e_nwe = (we && !e_err) ? 1 : 0;
    chk({tag, "_err"},   idx, 32'(err), 32'(e_err));
    chk({tag, "_rdata"}, idx, rdata, e_rdata);
    chk({tag, "_lat"},   idx, 32'(lat), 32'(e_lat));
    chk({tag, "_nwe"},   idx, 32'(nwe), 32'(e_nwe));
    chk({tag, "_busy"},  idx, 32'(busy_ok), 32'd1);
    if (e_nwe == 1) begin
      chk({tag, "_waddr"}, idx, waddr, {addr[31:2], 2'b00});
      chk({tag, "_wdata"}, idx, wdat, e_wword);
    end
  endtask

  initial begin
    logic m_err;
    logic [31:0] m_rdata, m_wword, eA, eB;
    int m_lat, m_nwe;
    logic [6:0] rsp_pat, rdy_pat;
    logic [31:0] rd_k2, rd_k5;
    logic quiet;

    for (int i = 0; i < int'(DEPTH); i++) mdl[i] = 32'd0;

    vt[0]  = '{1'b1, 2'd2, 32'h10,   32'hDEADBEEF, 1'b0, 32'h0,        2, 32'hDEADBEEF};
    vt[1]  = '{1'b0, 2'd2, 32'h10,   32'h0,        1'b0, 32'hDEADBEEF, 2, 32'h0};
    vt[2]  = '{1'b1, 2'd0, 32'h12,   32'hFFFFFF55, 1'b0, 32'h0,        3, 32'hDE55BEEF};
    vt[3]  = '{1'b0, 2'd0, 32'h12,   32'h0,        1'b0, 32'h55,       2, 32'h0};
    vt[4]  = '{1'b0, 2'd2, 32'h10,   32'h0,        1'b0, 32'hDE55BEEF, 2, 32'h0};
    vt[5]  = '{1'b1, 2'd2, 32'h14,   32'h11223344, 1'b0, 32'h0,        2, 32'h11223344};
    vt[6]  = '{1'b1, 2'd1, 32'h16,   32'h1234A5A5, 1'b0, 32'h0,        3, 32'hA5A53344};
    vt[7]  = '{1'b0, 2'd1, 32'h14,   32'h0,        1'b0, 32'h3344,     2, 32'h0};
    vt[8]  = '{1'b0, 2'd1, 32'h16,   32'h0,        1'b0, 32'hA5A5,     2, 32'h0};
    vt[9]  = '{1'b0, 2'd2, 32'h14,   32'h0,        1'b0, 32'hA5A53344, 2, 32'h0};
    vt[10] = '{1'b1, 2'd1, 32'h13,   32'h5A5A,     1'b1, 32'h0,        1, 32'h0};
    vt[11] = '{1'b0, 2'd2, 32'h02,   32'h0,        1'b1, 32'h0,        1, 32'h0};
    vt[12] = '{1'b0, 2'd3, 32'h20,   32'h0,        1'b1, 32'h0,        1, 32'h0};
    vt[13] = '{1'b1, 2'd2, 32'h4000, 32'hCAFEF00D, 1'b1, 32'h0,        1, 32'h0};
    vt[14] = '{1'b1, 2'd2, 32'h3FFC, 32'h89ABCDEF, 1'b0, 32'h0,        2, 32'h89ABCDEF};
    vt[15] = '{1'b0, 2'd0, 32'h3FFF, 32'h0,        1'b0, 32'h89,       2, 32'h0};
    vt[16] = '{1'b0, 2'd0, 32'h11,   32'h0,        1'b0, 32'hBE,       2, 32'h0};
    vt[17] = '{1'b1, 2'd0, 32'h10,   32'h123456AA, 1'b0, 32'h0,        3, 32'hDE55BEAA};
    vt[18] = '{1'b0, 2'd2, 32'h10,   32'h0,        1'b0, 32'hDE55BEAA, 2, 32'h0};
    vt[19] = '{1'b0, 2'd0, 32'h13,   32'h0,        1'b0, 32'hDE,       2, 32'h0};

    // Reset values
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ready", 0, 32'(ready_o), 32'd1);
    chk("rst_rsp",   0, 32'(rsp_valid_o), 32'd0);
    chk("rst_err",   0, 32'(err_o), 32'd0);
    chk("rst_rdata", 0, rdata_o, 32'd0);
    chk("rst_we",    0, 32'(ram_we_o), 32'd0);
    chk("rst_raddr", 0, ram_addr_o, 32'd0);
    chk("rst_rdat",  0, ram_data_o, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    ram_init = 1'b0;

    // Directed vector table
    for (int i = 0; i < NV; i++) begin
      model(vt[i].we, vt[i].size, vt[i].addr, vt[i].wdata, m_err, m_rdata, m_lat, m_nwe, m_wword);
      check_req("vec", i, vt[i].we, vt[i].size, vt[i].addr, vt[i].wdata,
                vt[i].err, vt[i].rdata, vt[i].lat, vt[i].wword);
    end

    // Back-to-back with req_i held high through the response
    model(1'b0, 2'd2, 32'h10, 32'h0, m_err, eA, m_lat, m_nwe, m_wword);
    model(1'b0, 2'd1, 32'h16, 32'h0, m_err, eB, m_lat, m_nwe, m_wword);
    rsp_pat = '0; rdy_pat = '0; rd_k2 = '0; rd_k5 = '0;
    @(negedge clk);
    req_i = 1'b1; we_i = 1'b0; size_i = 2'd2; addr_i = 32'h10; wdata_i = 32'h0;
    @(posedge clk);
    for (int k = 1; k <= 7; k++) begin
      if (k > 1) @(posedge clk);
      #1;
      rsp_pat[k-1] = rsp_valid_o;
      rdy_pat[k-1] = ready_o;
      if (k == 2) begin
        rd_k2 = rdata_o;
        size_i = 2'd1; addr_i = 32'h16;
      end
      if (k == 4) req_i = 1'b0;
      if (k == 5) rd_k5 = rdata_o;
    end
    chk("b2b_rsp",   0, 32'(rsp_pat), 32'(7'b0010010));
    chk("b2b_ready", 0, 32'(rdy_pat), 32'(7'b1100100));
    chk("b2b_rdA",   0, rd_k2, eA);
    chk("b2b_rdB",   0, rd_k5, eB);

    // Reset during the write phase of a sub-word store
    model(1'b1, 2'd2, 32'h18, 32'h01020304, m_err, m_rdata, m_lat, m_nwe, m_wword);
    check_req("pre", 0, 1'b1, 2'd2, 32'h18, 32'h01020304, 1'b0, 32'h0, 2, 32'h01020304);
    @(negedge clk);
    req_i = 1'b1; we_i = 1'b1; size_i = 2'd0; addr_i = 32'h19; wdata_i = 32'h77;
    @(posedge clk);
    #1;
    req_i = 1'b0;
    chk("mid_read_we", 0, 32'(ram_we_o), 32'd0);
    @(posedge clk);
    #1;
    chk("mid_write_we", 0, 32'(ram_we_o), 32'd1);
    #2;
    rst = 1'b1;
    #1;
    chk("arst_we",    0, 32'(ram_we_o), 32'd0);
    chk("arst_ready", 0, 32'(ready_o), 32'd1);
    chk("arst_rsp",   0, 32'(rsp_valid_o), 32'd0);
    chk("arst_raddr", 0, ram_addr_o, 32'd0);
    chk("arst_rdat",  0, ram_data_o, 32'd0);
    chk("arst_rdata", 0, rdata_o, 32'd0);
    chk("arst_err",   0, 32'(err_o), 32'd0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    quiet = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(posedge clk);
      #1;
      if (rsp_valid_o || !ready_o || ram_we_o) quiet = 1'b0;
    end
    chk("post_rst_quiet", 0, 32'(quiet), 32'd1);
    model(1'b0, 2'd2, 32'h18, 32'h0, m_err, m_rdata, m_lat, m_nwe, m_wword);
    check_req("post_rst_ld", 0, 1'b0, 2'd2, 32'h18, 32'h0, m_err, m_rdata, m_lat, m_wword);

    // Random requests against the model
    for (int i = 0; i < 300; i++) begin
      logic        r_we;
      logic [1:0]  r_size;
      logic [31:0] r_addr, r_wdata;
      int          widx;
      r_we    = 1'($urandom_range(0, 1));
      r_size  = ($urandom_range(0, 9) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
      widx    = ($urandom_range(0, 9) == 0) ? int'($urandom_range(DEPTH - 4, DEPTH + 3))
                                            : int'($urandom_range(0, 63));
      r_addr  = (32'(widx) << 2) | 32'($urandom_range(0, 3));
      r_wdata = $urandom;
      model(r_we, r_size, r_addr, r_wdata, m_err, m_rdata, m_lat, m_nwe, m_wword);
      check_req("rnd", i, r_we, r_size, r_addr, r_wdata, m_err, m_rdata, m_lat, m_wword);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
